byte_transmitter: RTL

UART transmit engine, the sending counterpart of the peripheral UART byte receiver. It accepts bytes from the CPU/peripheral bus into a small FIFO and serialises each byte as 8N1 frames on `uart_tx_pin`. Frames are paced by the shared `baud_oversample_clk` enable, which runs at 8× the baud rate. The block sits in `peripheral/uart` beside the receiver and shares its oversample enable.

---
 rtl/byte_transmitter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/byte_transmitter.sv
// UART 8N1 transmit engine: small byte FIFO feeding a frame serialiser paced
// by the shared oversample enable (OVERSAMPLE ticks per bit).
module byte_transmitter #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_oversample_clk,
    input  logic [7:0] byte_data,
    input  logic       byte_write,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_tx_pin
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CTR_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state, state_n;
    logic [CTR_W-1:0] ctr, ctr_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             pin_n;
    logic             busy_n;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_n;
    logic             push, pop;
    logic             fifo_empty;
    logic             bit_end;
    logic [7:0]       head;

    assign fifo_empty = (count == '0);
    assign tx_ready   = (count != CNT_FULL);
    assign push       = byte_write && tx_ready;
    assign bit_end    = (ctr == CTR_LAST);
    assign head       = mem[rd_ptr];

    // Frame sequencing; everything except the FIFO write side moves only on ticks.
    always_comb begin
        state_n   = state;
        ctr_n     = ctr;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pin_n     = uart_tx_pin;
        pop       = 1'b0;
        if (baud_oversample_clk) begin
            case (state)
                S_IDLE: begin
                    pin_n = 1'b1;
                    ctr_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = S_START;
                        pin_n   = 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_n   = S_DATA;
                        bit_idx_n = 3'd0;
                        pin_n     = shift[0];
                        ctr_n     = '0;
                    end else begin
                        ctr_n = ctr + CTR_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        ctr_n   = '0;
                        shift_n = {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_n = S_STOP;
                            pin_n   = 1'b1;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                            pin_n     = shift[1];
                        end
                    end else begin
                        ctr_n = ctr + CTR_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        ctr_n = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_n = head;
                            state_n = S_START;
                            pin_n   = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                            pin_n   = 1'b1;
                        end
                    end else begin
                        ctr_n = ctr + CTR_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    pin_n   = 1'b1;
                    ctr_n   = '0;
                end
            endcase
        end
    end

    // Occupancy tracking and registered busy flag.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
        busy_n = (state_n != S_IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ctr         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'd0;
            uart_tx_pin <= 1'b1;
            tx_busy     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state       <= state_n;
            ctr         <= ctr_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            uart_tx_pin <= pin_n;
            tx_busy     <= busy_n;
            count       <= count_n;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage carries no reset; contents are qualified by the count.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= byte_data;
    end

endmodule
